hebbian_learner_seq: RTL and testbench

HEBBIAN_LEARNER_SEQ -- requirements
Module: hebbian_learner_seq

---
 rtl/hebbian_learner_seq.sv | 180 ++++++++++++++++++
 tb/tb_hebbian_learner_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hebbian_learner_seq.sv
// Sequential Hebbian learner: one row-major sweep over an N x N signed weight
// array, one synapse per cycle, with Hebbian, decay, clear and no-op modes.
module hebbian_learner_seq #(
    parameter int                    N           = 7,
    parameter int                    N_EXC       = 6,
    parameter int                    WW          = 16,
    parameter int                    ETA         = 4,
    parameter logic signed [WW-1:0]  W_MAX       = 16'sh7FFF,
    parameter logic signed [WW-1:0]  W_MIN       = 16'sh8000,
    parameter int                    DECAY_SHIFT = 4,
    localparam int                   IW          = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         spikes,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag,
    input  logic [IW-1:0]        rd_i,
    input  logic [IW-1:0]        rd_j,
    output logic signed [WW-1:0] rd_data
);

    localparam logic [1:0]            MODE_HEBB = 2'b00;
    localparam logic [1:0]            MODE_DCAY = 2'b01;
    localparam logic [1:0]            MODE_CLR  = 2'b10;
    localparam logic [IW-1:0]         LAST_IDX  = IW'(N - 32'd1);
    localparam logic [IW-1:0]         ONE_IDX   = IW'(1'b1);
    localparam logic signed [WW:0]    ETA_X     = (WW+1)'(ETA);
    localparam logic signed [WW:0]    W_MAX_X   = {W_MAX[WW-1], W_MAX};
    localparam logic signed [WW:0]    W_MIN_X   = {W_MIN[WW-1], W_MIN};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_r;
    logic [IW-1:0]         i_r;
    logic [IW-1:0]         j_r;
    logic [N-1:0]          spikes_r;
    logic [1:0]            mode_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  sat_r;
    logic signed [WW-1:0]  weight_r [N][N];

    logic signed [WW-1:0]  cur_w_s;
    logic signed [WW-1:0]  new_w_s;
    logic signed [WW-1:0]  decay_s;
    logic signed [WW:0]    delta_s;
    logic signed [WW:0]    sum_s;
    logic                  diag_s;
    logic                  coact_s;
    logic                  exc_pair_s;
    logic                  clamp_s;

    // Next value of the synapse currently visited, with its clamp indicator.
    always_comb begin
        cur_w_s    = weight_r[i_r][j_r];
        diag_s     = (i_r == j_r);
        coact_s    = spikes_r[i_r] & spikes_r[j_r];
        exc_pair_s = (int'(i_r) < N_EXC) && (int'(j_r) < N_EXC);
        if (coact_s) begin
            delta_s = exc_pair_s ? ETA_X : -ETA_X;
        end else begin
            delta_s = {(WW+1){1'b0}};
        end
        // Sum one bit wider than storage so overflow is visible to the clamp.
        sum_s   = {cur_w_s[WW-1], cur_w_s} + delta_s;
        decay_s = cur_w_s - (cur_w_s >>> DECAY_SHIFT);
        new_w_s = cur_w_s;
        clamp_s = 1'b0;
        case (mode_r)
            MODE_HEBB: begin
                if (diag_s) begin
                    new_w_s = cur_w_s;
                end else if (sum_s > W_MAX_X) begin
                    new_w_s = W_MAX;
                    clamp_s = 1'b1;
                end else if (sum_s < W_MIN_X) begin
                    new_w_s = W_MIN;
                    clamp_s = 1'b1;
                end else begin
                    new_w_s = sum_s[WW-1:0];
                end
            end
            MODE_DCAY: begin
                if (diag_s) begin
                    new_w_s = cur_w_s;
                end else begin
                    new_w_s = decay_s;
                end
            end
            MODE_CLR: begin
                new_w_s = {WW{1'b0}};
            end
            default: begin
                new_w_s = cur_w_s;
            end
        endcase
    end

    // Sweep controller, pair counters and weight storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            i_r      <= {IW{1'b0}};
            j_r      <= {IW{1'b0}};
            spikes_r <= {N{1'b0}};
            mode_r   <= 2'b00;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sat_r    <= 1'b0;
            for (int a = 0; a < N; a++) begin
                for (int b = 0; b < N; b++) begin
                    weight_r[a][b] <= {WW{1'b0}};
                end
            end
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        spikes_r <= spikes;
                        mode_r   <= mode;
                        i_r      <= {IW{1'b0}};
                        j_r      <= {IW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= SWEEP;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                SWEEP: begin
                    weight_r[i_r][j_r] <= new_w_s;
                    if (clamp_s) begin
                        sat_r <= 1'b1;
                    end
                    if ((i_r == LAST_IDX) && (j_r == LAST_IDX)) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                        if (mode_r == MODE_CLR) begin
                            sat_r <= 1'b0;
                        end
                    end else if (j_r == LAST_IDX) begin
                        j_r <= {IW{1'b0}};
                        i_r <= i_r + ONE_IDX;
                    end else begin
                        j_r <= j_r + ONE_IDX;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read port; indices beyond the array read as zero.
    always_comb begin
        rd_data = {WW{1'b0}};
        if ((int'(rd_i) < N) && (int'(rd_j) < N)) begin
            rd_data = weight_r[rd_i][rd_j];
        end else begin
            rd_data = {WW{1'b0}};
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sat_flag = sat_r;

endmodule

// File: tb/tb_hebbian_learner_seq.sv
// Randomized self-checking bench for hebbian_learner_seq, built with tight
// clamp bounds and a small decay shift so saturation and decay are reachable.
module tb_hebbian_learner_seq;

    localparam int N     = 7;
    localparam int N_EXC = 6;
    localparam int WW    = 16;
    localparam int ETA   = 4;
    localparam int DS    = 2;
    localparam int W_HI  = 8;
    localparam int W_LO  = -12;
    localparam int IW    = 3;
    localparam int NN    = N * N;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [1:0]           mode;
    logic [N-1:0]         spikes;
    logic                 busy;
    logic                 done;
    logic                 sat_flag;
    logic [IW-1:0]        rd_i;
    logic [IW-1:0]        rd_j;
    logic signed [WW-1:0] rd_data;

    int model_w [N][N];
    int prev_w  [N][N];
    int obs_w   [N][N];
    bit model_sat;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hebbian_learner_seq #(
        .N(N), .N_EXC(N_EXC), .WW(WW), .ETA(ETA),
        .W_MAX(16'sh0008), .W_MIN(16'shFFF4), .DECAY_SHIFT(DS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .spikes(spikes), .busy(busy), .done(done), .sat_flag(sat_flag),
        .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data)
    );

    function automatic int floor_div(input int a, input int d);
        int q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: apply one whole sweep to the model array.
    task automatic model_sweep(input logic [1:0] m, input logic [N-1:0] s);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int v = model_w[i][j];
                if (m == 2'b10) begin
                    v = 0;
                end else if (i != j && m == 2'b00) begin
                    int c = (s[i] && s[j]) ? 1 : 0;
                    v = v + ((i < N_EXC && j < N_EXC) ? ETA : -ETA) * c;
                    if (v > W_HI) begin v = W_HI; model_sat = 1'b1; end
                    if (v < W_LO) begin v = W_LO; model_sat = 1'b1; end
                end else if (i != j && m == 2'b01) begin
                    v = v - floor_div(v, 2 ** DS);
                end
                model_w[i][j] = v;
            end
        end
        if (m == 2'b10) model_sat = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                model_w[i][j] = 0;
        model_sat = 1'b0;
    endtask

    task automatic read_w(input int i, input int j, output int v);
        rd_i = IW'(i);
        rd_j = IW'(j);
        #1;
        v = int'(rd_data);
    endtask

    task automatic read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                read_w(i, j, obs_w[i][j]);
    endtask

    // Drives one sweep starting now; reports when done appeared and whether busy held.
    task automatic run_sweep(input logic [1:0] m, input logic [N-1:0] s, input bit disturb,
                             input int peek_k, output int done_at, output bit busy_ok,
                             output int peek_new, output int peek_old);
        mode = m; spikes = s; start = 1'b1;
        done_at = -1; busy_ok = 1'b1; peek_new = 0; peek_old = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                done_at = c;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (disturb && c == 9)  begin start = 1'b1; spikes = ~s; mode = ~m; end
            if (disturb && c == 10) start = 1'b0;
            if (disturb && c == 20) spikes = N'($urandom);
            if (c == peek_k + 1) begin
                read_w(peek_k / N, peek_k % N, peek_new);
                read_w((peek_k + 1) / N, (peek_k + 1) % N, peek_old);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; mode = 2'b00; spikes = '0; rd_i = '0; rd_j = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL reset_sat: got %b expected 0", sat_flag); else n_pass++;
        read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== 0) $display("FAIL reset_w[%0d][%0d]: got %0d expected 0", i, j, obs_w[i][j]);
                else n_pass++;
            end
    endtask

    task automatic test_hebbian_basic();
        int da, pn, po; bit bok; int v;
        @(negedge clk);
        prev_w = model_w;
        model_sweep(2'b00, 7'b0000011);
        run_sweep(2'b00, 7'b0000011, 1'b0, 1, da, bok, pn, po);
        n_checks++; if (da !== NN) $display("FAIL hebb_done_cycle: got %0d expected %0d", da, NN); else n_pass++;
        n_checks++; if (bok !== 1'b1) $display("FAIL hebb_busy_window: got %b expected 1", bok); else n_pass++;
        n_checks++; if (pn !== 4) $display("FAIL hebb_peek_written: got %0d expected 4", pn); else n_pass++;
        n_checks++; if (po !== prev_w[0][2]) $display("FAIL hebb_peek_pending: got %0d expected %0d", po, prev_w[0][2]); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL hebb_done_pulse: got %b expected 0", done); else n_pass++;
        read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== model_w[i][j])
                    $display("FAIL hebb_w[%0d][%0d]: got %0d expected %0d", i, j, obs_w[i][j], model_w[i][j]);
                else n_pass++;
            end
        n_checks++; if (obs_w[0][1] !== 4 || obs_w[1][0] !== 4)
            $display("FAIL hebb_pair01: got %0d/%0d expected 4/4", obs_w[0][1], obs_w[1][0]); else n_pass++;
        read_w(7, 1, v);
        n_checks++; if (v !== 0) $display("FAIL read_out_of_range: got %0d expected 0", v); else n_pass++;
    endtask

    task automatic test_inhibitory_decay();
        int da, pn, po; bit bok;
        @(negedge clk);
        model_sweep(2'b10, '0);
        run_sweep(2'b10, '0, 1'b0, -1, da, bok, pn, po);
        model_sweep(2'b00, 7'b1000001);
        run_sweep(2'b00, 7'b1000001, 1'b0, -1, da, bok, pn, po);
        read_all();
        n_checks++; if (obs_w[0][6] !== -4 || obs_w[6][0] !== -4)
            $display("FAIL inhib_pair06: got %0d/%0d expected -4/-4", obs_w[0][6], obs_w[6][0]); else n_pass++;
        @(negedge clk);
        model_sweep(2'b01, '0);
        run_sweep(2'b01, '0, 1'b0, -1, da, bok, pn, po);
        n_checks++; if (da !== NN) $display("FAIL decay_done_cycle: got %0d expected %0d", da, NN); else n_pass++;
        read_all();
        n_checks++; if (obs_w[0][6] !== -3) $display("FAIL decay_w06: got %0d expected -3", obs_w[0][6]); else n_pass++;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== model_w[i][j])
                    $display("FAIL decay_w[%0d][%0d]: got %0d expected %0d", i, j, obs_w[i][j], model_w[i][j]);
                else n_pass++;
            end
    endtask

    task automatic test_saturation();
        int da, pn, po; bit bok;
        @(negedge clk);
        model_sweep(2'b10, '0);
        run_sweep(2'b10, '0, 1'b0, -1, da, bok, pn, po);
        for (int k = 0; k < 3; k++) begin
            model_sweep(2'b00, 7'b0000011);
            run_sweep(2'b00, 7'b0000011, 1'b0, -1, da, bok, pn, po);
            if (k == 1) begin
                n_checks++; if (sat_flag !== 1'b0) $display("FAIL sat_at_bound: got %b expected 0", sat_flag); else n_pass++;
            end
        end
        read_all();
        n_checks++; if (obs_w[0][1] !== W_HI) $display("FAIL sat_w01: got %0d expected %0d", obs_w[0][1], W_HI); else n_pass++;
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat_flag_set: got %b expected 1", sat_flag); else n_pass++;
        @(negedge clk);
        model_sweep(2'b10, '0);
        run_sweep(2'b10, '0, 1'b0, -1, da, bok, pn, po);
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL clear_sat: got %b expected 0", sat_flag); else n_pass++;
        read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== 0) $display("FAIL clear_w[%0d][%0d]: got %0d expected 0", i, j, obs_w[i][j]);
                else n_pass++;
            end
    endtask

    task automatic test_restart_ignored();
        int da, pn, po; bit bok; logic [N-1:0] s;
        @(negedge clk);
        s = N'($urandom);
        model_sweep(2'b00, s);
        run_sweep(2'b00, s, 1'b1, 30, da, bok, pn, po);
        n_checks++; if (da !== NN) $display("FAIL restart_done_cycle: got %0d expected %0d", da, NN); else n_pass++;
        n_checks++; if (bok !== 1'b1) $display("FAIL restart_busy_window: got %b expected 1", bok); else n_pass++;
        n_checks++; if (pn !== model_w[30 / N][30 % N])
            $display("FAIL restart_peek: got %0d expected %0d", pn, model_w[30 / N][30 % N]); else n_pass++;
        read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== model_w[i][j])
                    $display("FAIL restart_w[%0d][%0d]: got %0d expected %0d", i, j, obs_w[i][j], model_w[i][j]);
                else n_pass++;
            end
    endtask

    task automatic test_back_to_back();
        int da, pn, po; bit bok; logic [N-1:0] s;
        @(negedge clk);
        model_sweep(2'b11, 7'b1111111);
        run_sweep(2'b11, 7'b1111111, 1'b0, -1, da, bok, pn, po);
        n_checks++; if (da !== NN) $display("FAIL noop_done_cycle: got %0d expected %0d", da, NN); else n_pass++;
        s = N'($urandom);
        prev_w = model_w;
        model_sweep(2'b00, s);
        run_sweep(2'b00, s, 1'b0, 10, da, bok, pn, po);
        n_checks++; if (bok !== 1'b1) $display("FAIL b2b_accept_busy: got %b expected 1", bok); else n_pass++;
        n_checks++; if (da !== NN) $display("FAIL b2b_done_cycle: got %0d expected %0d", da, NN); else n_pass++;
        n_checks++; if (po !== prev_w[11 / N][11 % N])
            $display("FAIL b2b_peek_pending: got %0d expected %0d", po, prev_w[11 / N][11 % N]); else n_pass++;
        read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== model_w[i][j])
                    $display("FAIL b2b_w[%0d][%0d]: got %0d expected %0d", i, j, obs_w[i][j], model_w[i][j]);
                else n_pass++;
            end
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            int r, pk, da, pn, po; bit bok; logic [1:0] m; logic [N-1:0] s;
            r  = $urandom_range(0, 9);
            m  = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b10;
            s  = N'($urandom);
            pk = $urandom_range(0, NN - 2);
            @(negedge clk);
            prev_w = model_w;
            model_sweep(m, s);
            run_sweep(m, s, 1'b0, pk, da, bok, pn, po);
            n_checks++; if (da !== NN || bok !== 1'b1)
                $display("FAIL rand_timing it%0d: got done %0d busy_ok %b expected %0d/1", it, da, bok, NN); else n_pass++;
            n_checks++; if (pn !== model_w[pk / N][pk % N])
                $display("FAIL rand_peek_new it%0d: got %0d expected %0d", it, pn, model_w[pk / N][pk % N]); else n_pass++;
            n_checks++; if (po !== prev_w[(pk + 1) / N][(pk + 1) % N])
                $display("FAIL rand_peek_old it%0d: got %0d expected %0d", it, po, prev_w[(pk + 1) / N][(pk + 1) % N]); else n_pass++;
            n_checks++; if (sat_flag !== model_sat)
                $display("FAIL rand_sat it%0d: got %b expected %b", it, sat_flag, model_sat); else n_pass++;
            read_all();
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    n_checks++;
                    if (obs_w[i][j] !== model_w[i][j])
                        $display("FAIL rand_w it%0d [%0d][%0d]: got %0d expected %0d", it, i, j, obs_w[i][j], model_w[i][j]);
                    else n_pass++;
                end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int da, pn, po; bit bok;
        @(negedge clk);
        mode = 2'b00; spikes = 7'b1111111; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0)
            $display("FAIL midreset_flags: got busy %b done %b sat %b expected 0/0/0", busy, done, sat_flag); else n_pass++;
        read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== 0) $display("FAIL midreset_w[%0d][%0d]: got %0d expected 0", i, j, obs_w[i][j]);
                else n_pass++;
            end
        @(negedge clk);
        reset_n = 1'b1;
        model_sweep(2'b00, 7'b0000011);
        run_sweep(2'b00, 7'b0000011, 1'b0, -1, da, bok, pn, po);
        n_checks++; if (bok !== 1'b1 || da !== NN)
            $display("FAIL postreset_sweep: got busy_ok %b done %0d expected 1/%0d", bok, da, NN); else n_pass++;
        read_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_checks++;
                if (obs_w[i][j] !== model_w[i][j])
                    $display("FAIL postreset_w[%0d][%0d]: got %0d expected %0d", i, j, obs_w[i][j], model_w[i][j]);
                else n_pass++;
            end
    endtask

    initial begin
        test_reset();
        test_hebbian_basic();
        test_inhibitory_decay();
        test_saturation();
        test_restart_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
